instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- IF stage of the RV32IM pipeline, directly upstream of the instruction cache.
- Owns the PC and drives the cache read request and address.
- Accepts the fetched 32-bit word, loads the IF/ID pipeline register, handles ID-stage stalls via a one-entry skid register, and handles EX-stage redirects (branch/jump), including a redirect that arrives during an outstanding cache miss.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction presented on IF/ID when it is invalid or flushed (addi x0,x0,0).

Ports:
- clock  in  1  single clock, all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- ICACHE_READ  out  1  read request to the instruction cache.
- ICACHE_ADDRESS  out  32  fetch address (current PC), word aligned.
- ICACHE_READDATA  in  32  instruction word from the cache.
- ICACHE_BUSYWAIT  in  1  cache busy; high while a request is unresolved.
- STALL  in  1  ID hazard stall: hold IF/ID and PC.
- BRANCH_TAKEN  in  1  EX redirect valid.
- BRANCH_TARGET  in  32  redirect address; bits [1:0] ignored (forced 0).
- IF_ID_INSTRUCTION  out  32  instruction to ID.
- IF_ID_PC  out  32  PC of IF_ID_INSTRUCTION.
- IF_ID_PC_PLUS4  out  32  IF_ID_PC + 4.
- IF_ID_VALID  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset (async):
  - pc=RESET_PC, state=ISSUE, ICACHE_READ=0, skid empty, pending target cleared.
  - IF_ID_VALID=0, IF_ID_INSTRUCTION=NOP_INSTR, IF_ID_PC=0, IF_ID_PC_PLUS4=0.
  - ICACHE_ADDRESS follows pc (=RESET_PC).
- Cache handshake:
  - The cache detects a request on the rising edge of ICACHE_READ.
  - Therefore ICACHE_READ is low for at least one cycle between requests.
  - ICACHE_ADDRESS is stable for the whole time ICACHE_READ is high.
  - A fetch completes at a posedge where ICACHE_READ=1, ICACHE_BUSYWAIT=0, and ICACHE_READ was already 1 at the previous posedge. ICACHE_READDATA is sampled at that edge.
- State ISSUE: ICACHE_READ=0.
  - If BRANCH_TAKEN: pc<=target, IF_ID_VALID<=0, stay in ISSUE.
  - Else if STALL: stay in ISSUE.
  - Else: go to WAIT.
- State WAIT: ICACHE_READ=1, address=pc.
  - BRANCH_TAKEN with no completion: latch target into pending, IF_ID_VALID<=0, go to DISCARD.
  - BRANCH_TAKEN with completion: drop the word, pc<=target, IF_ID_VALID<=0, go to ISSUE.
  - Completion and !STALL: IF/ID<={word, pc, pc+4, valid=1}, pc<=pc+4, go to ISSUE.
  - Completion and STALL: skid<={word, pc}, IF/ID unchanged, go to HOLD.
  - Otherwise: stay in WAIT.
- State DISCARD: ICACHE_READ=1, address=old pc (the cache miss cannot be aborted).
  - A further BRANCH_TAKEN overwrites pending (the latest target wins).
  - On completion: drop the word, pc<=pending, go to ISSUE.
  - IF_ID_VALID stays 0.
- State HOLD: ICACHE_READ=0.
  - BRANCH_TAKEN: drop skid, pc<=target, IF_ID_VALID<=0, go to ISSUE.
  - Else if !STALL: IF/ID<=skid (valid=1), pc<=pc+4, go to ISSUE.
- Priority: reset > BRANCH_TAKEN > STALL > completion.
  - A flush always clears IF_ID_VALID, even while STALL=1.
- When IF_ID_VALID=0: IF_ID_INSTRUCTION=NOP_INSTR. IF_ID_PC and IF_ID_PC_PLUS4 hold their previous values.
- Arithmetic: pc+4 is a 32-bit add; it wraps at 32'hFFFF_FFFC -> 32'h0000_0000 with no flag.
- Throughput: on a hit with no stall, one instruction every 3 cycles (ISSUE, WAIT with busy, WAIT with completion). A miss extends WAIT until busywait falls.
- Reset mid-miss: state returns to ISSUE, ICACHE_READ drops immediately, pending target and skid are discarded.

Decomposition:
- Package rv32_fetch_pkg contains:
  - State encoding: ISSUE, WAIT, DISCARD, HOLD (2 bits).
  - RESET_PC default and NOP_INSTR constant.
  - PC_INCREMENT = 4.
- One sub-module, if_id_register: 32+32+32+1 bit register with load, flush and hold controls, async reset to NOP/0/0/0. It is reusable for other pipeline registers.
- The FSM, PC, skid and pending-target logic stay in instruction_fetch_unit.

Test Plan:
- Reset, then a hit cache model (busywait falls 1 cycle after read rises) -> IF/ID shows PC 0x0,0x4,0x8 with VALID=1, one every 3 cycles; READ toggles low between fetches.
- Miss of 10 cycles at PC 0x10 -> ICACHE_ADDRESS held at 0x10 and READ held high for the whole miss; IF/ID loads PC 0x10, PC_PLUS4 0x14 on completion.
- BRANCH_TAKEN target 0x200 during the 10-cycle miss at 0x40 -> DISCARD; the returned word is dropped, VALID=0; the next request is at 0x200; a second redirect to 0x300 mid-miss results in a fetch at 0x300.
- STALL high when the fetch of 0x8 completes -> IF/ID keeps 0x4; STALL low for 1 cycle -> IF/ID=0x8 from skid, next request at 0xC.
- BRANCH_TAKEN target 0x103 together with STALL in HOLD -> skid dropped, VALID=0, next address 0x100.
- Assert reset during a miss -> READ=0 and VALID=0 immediately (before the next edge); fetch restarts at RESET_PC; PC 0xFFFFFFFC followed by sequential fetch wraps to 0x0.

Source files
------------

// File: rtl/rv32_fetch_pkg.sv
// Shared types and constants for the RV32IM instruction fetch stage.
package rv32_fetch_pkg;

  typedef enum logic [1:0] {
    ISSUE   = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2,
    HOLD    = 2'd3
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_INCREMENT      = 32'd4;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction cache read bus between the fetch stage (master) and the cache (slave).
interface instruction_fetch_unit_if;
  logic        ICACHE_READ;
  logic [31:0] ICACHE_ADDRESS;
  logic [31:0] ICACHE_READDATA;
  logic        ICACHE_BUSYWAIT;

  modport master (
    output ICACHE_READ,
    output ICACHE_ADDRESS,
    input  ICACHE_READDATA,
    input  ICACHE_BUSYWAIT
  );

  modport slave (
    input  ICACHE_READ,
    input  ICACHE_ADDRESS,
    output ICACHE_READDATA,
    output ICACHE_BUSYWAIT
  );
endinterface

// File: rtl/if_id_register.sv
// Generic pipeline register: instruction, pc, pc+4 and valid with load/flush/hold.
module if_id_register
  import rv32_fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        flush_i,
  input  logic        hold_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] pc_plus4_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o
);

  logic [31:0] instr_q, pc_q, pc_plus4_q;
  logic        valid_q;

  // Flush outranks hold; pc fields are kept so ID can still see the last address.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      instr_q    <= NOP_INSTR;
      pc_q       <= 32'h0;
      pc_plus4_q <= 32'h0;
      valid_q    <= 1'b0;
    end else if (flush_i) begin
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (load_i && !hold_i) begin
      instr_q    <= instr_i;
      pc_q       <= pc_i;
      pc_plus4_q <= pc_plus4_i;
      valid_q    <= 1'b1;
    end
  end

  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the PC, drives the I-cache request, skids on ID stalls, handles redirects.
module instruction_fetch_unit
  import rv32_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic                     clock,
  input  logic                     reset,
  instruction_fetch_unit_if.master icache,
  input  logic                     STALL,
  input  logic                     BRANCH_TAKEN,
  input  logic [31:0]              BRANCH_TARGET,
  output logic [31:0]              IF_ID_INSTRUCTION,
  output logic [31:0]              IF_ID_PC,
  output logic [31:0]              IF_ID_PC_PLUS4,
  output logic                     IF_ID_VALID
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d, pending_q, pending_d;
  logic [31:0]  skid_instr_q, skid_instr_d, skid_pc_q, skid_pc_d;
  logic         read_prev_q;
  logic         read, complete;
  logic [31:0]  target;
  logic         ifid_load, ifid_flush;
  logic [31:0]  ifid_instr, ifid_pc;

  // Read is decoded from state so an async reset drops it without waiting for an edge.
  assign read     = (state_q == WAIT) || (state_q == DISCARD);
  assign complete = read && read_prev_q && !icache.ICACHE_BUSYWAIT;
  assign target   = {BRANCH_TARGET[31:2], 2'b00};

  assign icache.ICACHE_READ    = read;
  assign icache.ICACHE_ADDRESS = pc_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pending_d    = pending_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    ifid_load    = 1'b0;
    ifid_flush   = 1'b0;
    ifid_instr   = icache.ICACHE_READDATA;
    ifid_pc      = pc_q;
    unique case (state_q)
      ISSUE: begin
        if (BRANCH_TAKEN) begin
          pc_d       = target;
          ifid_flush = 1'b1;
        end else if (!STALL) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (BRANCH_TAKEN) begin
          ifid_flush = 1'b1;
          if (complete) begin
            pc_d    = target;
            state_d = ISSUE;
          end else begin
            pending_d = target;
            state_d   = DISCARD;
          end
        end else if (complete) begin
          if (STALL) begin
            skid_instr_d = icache.ICACHE_READDATA;
            skid_pc_d    = pc_q;
            state_d      = HOLD;
          end else begin
            ifid_load = 1'b1;
            pc_d      = pc_q + PC_INCREMENT;
            state_d   = ISSUE;
          end
        end
      end
      DISCARD: begin
        // The outstanding miss cannot be cancelled; the latest redirect wins once it lands.
        if (BRANCH_TAKEN) pending_d = target;
        if (complete) begin
          pc_d    = BRANCH_TAKEN ? target : pending_q;
          state_d = ISSUE;
        end
      end
      HOLD: begin
        if (BRANCH_TAKEN) begin
          pc_d       = target;
          ifid_flush = 1'b1;
          state_d    = ISSUE;
        end else if (!STALL) begin
          ifid_load  = 1'b1;
          ifid_instr = skid_instr_q;
          ifid_pc    = skid_pc_q;
          pc_d       = pc_q + PC_INCREMENT;
          state_d    = ISSUE;
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ISSUE;
      pc_q         <= RESET_PC;
      pending_q    <= 32'h0;
      skid_instr_q <= 32'h0;
      skid_pc_q    <= 32'h0;
      read_prev_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pending_q    <= pending_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      read_prev_q  <= read;
    end
  end

  if_id_register #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk_i      (clock),
    .rst_i      (reset),
    .load_i     (ifid_load),
    .flush_i    (ifid_flush),
    .hold_i     (STALL),
    .instr_i    (ifid_instr),
    .pc_i       (ifid_pc),
    .pc_plus4_i (ifid_pc + PC_INCREMENT),
    .instr_o    (IF_ID_INSTRUCTION),
    .pc_o       (IF_ID_PC),
    .pc_plus4_o (IF_ID_PC_PLUS4),
    .valid_o    (IF_ID_VALID)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit with a latency-programmable cache model.
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clock, reset;
  logic        STALL, BRANCH_TAKEN;
  logic [31:0] BRANCH_TARGET;
  logic [31:0] IF_ID_INSTRUCTION, IF_ID_PC, IF_ID_PC_PLUS4;
  logic        IF_ID_VALID;
  int          checks = 0;
  int          passes = 0;
  int          lat_cfg = 1;

  instruction_fetch_unit_if bus ();

  instruction_fetch_unit dut (
    .clock             (clock),
    .reset             (reset),
    .icache            (bus),
    .STALL             (STALL),
    .BRANCH_TAKEN      (BRANCH_TAKEN),
    .BRANCH_TARGET     (BRANCH_TARGET),
    .IF_ID_INSTRUCTION (IF_ID_INSTRUCTION),
    .IF_ID_PC          (IF_ID_PC),
    .IF_ID_PC_PLUS4    (IF_ID_PC_PLUS4),
    .IF_ID_VALID       (IF_ID_VALID)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0003;
  endfunction

  // Cache model: request seen on rising READ, data valid when BUSYWAIT falls.
  logic        rd_prev;
  int          cnt;
  logic [31:0] lat_addr;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.ICACHE_BUSYWAIT <= 1'b0;
      bus.ICACHE_READDATA <= 32'h0;
      rd_prev             <= 1'b0;
      cnt                 <= 0;
      lat_addr            <= 32'h0;
    end else begin
      rd_prev <= bus.ICACHE_READ;
      if (bus.ICACHE_READ && !rd_prev) begin
        lat_addr <= bus.ICACHE_ADDRESS;
        if (lat_cfg <= 1) begin
          bus.ICACHE_BUSYWAIT <= 1'b0;
          bus.ICACHE_READDATA <= mem(bus.ICACHE_ADDRESS);
        end else begin
          bus.ICACHE_BUSYWAIT <= 1'b1;
          cnt                 <= lat_cfg - 1;
        end
      end else if (bus.ICACHE_BUSYWAIT) begin
        if (cnt == 1) begin
          bus.ICACHE_BUSYWAIT <= 1'b0;
          bus.ICACHE_READDATA <= mem(lat_addr);
        end
        cnt <= cnt - 1;
      end
    end
  end

  // Reference model as flags: request outstanding, redirect owed, skid occupied.
  logic        m_req, m_prev, m_drop, m_skid, m_v;
  logic [31:0] m_pc, m_pend, m_sk_pc, m_instr, m_ifpc, m_ifpc4;

  task automatic model_reset();
    m_req = 0; m_prev = 0; m_drop = 0; m_skid = 0; m_v = 0;
    m_pc = 32'h0; m_pend = 32'h0; m_sk_pc = 32'h0;
    m_instr = NOP; m_ifpc = 32'h0; m_ifpc4 = 32'h0;
  endtask

  task automatic present(input logic [31:0] pc);
    m_v = 1; m_instr = mem(pc); m_ifpc = pc; m_ifpc4 = pc + 32'd4;
  endtask

  task automatic model_step(input logic st, input logic br, input logic [31:0] tg,
                            input logic busy);
    logic        done;
    logic [31:0] t;
    done   = m_req && m_prev && !busy;
    t      = tg & 32'hFFFF_FFFC;
    m_prev = m_req;
    if (m_skid) begin
      if (br) begin
        m_skid = 0; m_pc = t; m_v = 0; m_instr = NOP;
      end else if (!st) begin
        m_skid = 0; present(m_sk_pc); m_pc = m_sk_pc + 32'd4;
      end
    end else if (!m_req) begin
      if (br) begin
        m_pc = t; m_v = 0; m_instr = NOP;
      end else if (!st) m_req = 1;
    end else if (m_drop) begin
      if (br) m_pend = t;
      if (done) begin
        m_req = 0; m_drop = 0; m_pc = m_pend;
      end
    end else if (br) begin
      m_v = 0; m_instr = NOP;
      if (done) begin
        m_req = 0; m_pc = t;
      end else begin
        m_drop = 1; m_pend = t;
      end
    end else if (done) begin
      m_req = 0;
      if (st) begin
        m_skid = 1; m_sk_pc = m_pc;
      end else begin
        present(m_pc); m_pc = m_pc + 32'd4;
      end
    end
  endtask

  function automatic logic [129:0] dut_snap();
    return {bus.ICACHE_READ, bus.ICACHE_ADDRESS, IF_ID_VALID, IF_ID_INSTRUCTION, IF_ID_PC,
            IF_ID_PC_PLUS4};
  endfunction

  function automatic logic [129:0] model_snap();
    return {m_req, m_pc, m_v, m_instr, m_ifpc, m_ifpc4};
  endfunction

  // Called at a negedge; drives inputs, advances the model, returns at the next negedge.
  task automatic cycle(input logic st, input logic br, input logic [31:0] tg);
    STALL = st; BRANCH_TAKEN = br; BRANCH_TARGET = tg;
    model_step(st, br, tg, bus.ICACHE_BUSYWAIT);
    @(negedge clock);
    STALL = 1'b0; BRANCH_TAKEN = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; STALL = 1'b0; BRANCH_TAKEN = 1'b0; BRANCH_TARGET = 32'h0;
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic run_seq(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      cycle(1'b0, 1'b0, 32'h0);
      checks++;
      if (dut_snap() !== model_snap())
        $display("FAIL %s cyc%0d dut=%h model=%h", name, i, dut_snap(), model_snap());
      else passes++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; STALL = 1'b0; BRANCH_TAKEN = 1'b0; BRANCH_TARGET = 32'h0;
    model_reset();
    @(negedge clock);
    checks++;
    if (dut_snap() !== {1'b0, 32'h0, 1'b0, NOP, 32'h0, 32'h0})
      $display("FAIL reset_state dut=%h want=%h", dut_snap(), {1'b0, 32'h0, 1'b0, NOP, 64'h0});
    else passes++;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_hit_stream();
    do_reset();
    lat_cfg = 1;
    for (int k = 0; k < 3; k++) begin
      run_seq("hit_stream", 3);
      checks++;
      if (IF_ID_VALID !== 1'b1 || IF_ID_PC !== 32'(4 * k) || bus.ICACHE_READ !== 1'b0)
        $display("FAIL hit_pc%0d got pc=%h v=%b rd=%b want pc=%h v=1 rd=0", k, IF_ID_PC,
                 IF_ID_VALID, bus.ICACHE_READ, 32'(4 * k));
      else passes++;
    end
  endtask

  task automatic test_miss();
    do_reset();
    lat_cfg = 1;
    run_seq("miss_pre", 12);
    lat_cfg = 10;
    for (int i = 0; i < 11; i++) begin
      cycle(1'b0, 1'b0, 32'h0);
      checks++;
      if (bus.ICACHE_READ !== 1'b1 || bus.ICACHE_ADDRESS !== 32'h10)
        $display("FAIL miss_hold cyc%0d got rd=%b addr=%h want rd=1 addr=00000010", i,
                 bus.ICACHE_READ, bus.ICACHE_ADDRESS);
      else passes++;
    end
    cycle(1'b0, 1'b0, 32'h0);
    checks++;
    if (IF_ID_PC !== 32'h10 || IF_ID_PC_PLUS4 !== 32'h14 || IF_ID_VALID !== 1'b1
        || IF_ID_INSTRUCTION !== mem(32'h10))
      $display("FAIL miss_done got pc=%h pc4=%h v=%b ins=%h want 10/14/1/%h", IF_ID_PC,
               IF_ID_PC_PLUS4, IF_ID_VALID, IF_ID_INSTRUCTION, mem(32'h10));
    else passes++;
  endtask

  task automatic test_redirect_miss();
    do_reset();
    lat_cfg = 1;
    run_seq("redir_pre", 48);
    lat_cfg = 10;
    run_seq("redir_issue", 2);
    cycle(1'b0, 1'b1, 32'h200);
    checks++;
    if (IF_ID_VALID !== 1'b0 || bus.ICACHE_READ !== 1'b1 || bus.ICACHE_ADDRESS !== 32'h40)
      $display("FAIL redir_discard got v=%b rd=%b addr=%h want 0/1/00000040", IF_ID_VALID,
               bus.ICACHE_READ, bus.ICACHE_ADDRESS);
    else passes++;
    run_seq("redir_wait", 2);
    cycle(1'b0, 1'b1, 32'h300);
    checks++;
    if (dut_snap() !== model_snap())
      $display("FAIL redir_second dut=%h model=%h", dut_snap(), model_snap());
    else passes++;
    run_seq("redir_drain", 6);
    checks++;
    if (bus.ICACHE_READ !== 1'b0 || bus.ICACHE_ADDRESS !== 32'h300 || IF_ID_VALID !== 1'b0)
      $display("FAIL redir_target got rd=%b addr=%h v=%b want 0/00000300/0", bus.ICACHE_READ,
               bus.ICACHE_ADDRESS, IF_ID_VALID);
    else passes++;
    lat_cfg = 1;
    run_seq("redir_fetch", 3);
    checks++;
    if (IF_ID_PC !== 32'h300 || IF_ID_VALID !== 1'b1)
      $display("FAIL redir_fetch got pc=%h v=%b want 00000300/1", IF_ID_PC, IF_ID_VALID);
    else passes++;
  endtask

  task automatic test_stall_skid();
    do_reset();
    lat_cfg = 1;
    run_seq("skid_pre", 8);
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    checks++;
    if (IF_ID_PC !== 32'h4 || IF_ID_VALID !== 1'b1 || bus.ICACHE_READ !== 1'b0)
      $display("FAIL skid_hold got pc=%h v=%b rd=%b want 00000004/1/0", IF_ID_PC,
               IF_ID_VALID, bus.ICACHE_READ);
    else passes++;
    cycle(1'b0, 1'b0, 32'h0);
    checks++;
    if (IF_ID_PC !== 32'h8 || IF_ID_INSTRUCTION !== mem(32'h8) || bus.ICACHE_ADDRESS !== 32'hC)
      $display("FAIL skid_release got pc=%h ins=%h addr=%h want 00000008/%h/0000000c",
               IF_ID_PC, IF_ID_INSTRUCTION, bus.ICACHE_ADDRESS, mem(32'h8));
    else passes++;
    run_seq("skid_next", 1);
  endtask

  task automatic test_hold_branch();
    do_reset();
    lat_cfg = 1;
    run_seq("holdbr_pre", 8);
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 32'h103);
    checks++;
    if (IF_ID_VALID !== 1'b0 || IF_ID_INSTRUCTION !== NOP || bus.ICACHE_ADDRESS !== 32'h100)
      $display("FAIL hold_branch got v=%b ins=%h addr=%h want 0/%h/00000100", IF_ID_VALID,
               IF_ID_INSTRUCTION, bus.ICACHE_ADDRESS, NOP);
    else passes++;
    run_seq("holdbr_next", 4);
  endtask

  task automatic test_reset_mid_and_wrap();
    do_reset();
    lat_cfg = 1;
    run_seq("rstmid_pre", 3);
    lat_cfg = 10;
    run_seq("rstmid_miss", 3);
    #1 reset = 1'b1;
    #1;
    checks++;
    if (bus.ICACHE_READ !== 1'b0 || IF_ID_VALID !== 1'b0 || bus.ICACHE_ADDRESS !== 32'h0
        || IF_ID_INSTRUCTION !== NOP)
      $display("FAIL reset_async got rd=%b v=%b addr=%h ins=%h want 0/0/00000000/%h",
               bus.ICACHE_READ, IF_ID_VALID, bus.ICACHE_ADDRESS, IF_ID_INSTRUCTION, NOP);
    else passes++;
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    lat_cfg = 1;
    run_seq("rstmid_restart", 3);
    cycle(1'b0, 1'b1, 32'hFFFF_FFFC);
    run_seq("wrap_a", 3);
    checks++;
    if (IF_ID_PC !== 32'hFFFF_FFFC || IF_ID_PC_PLUS4 !== 32'h0 || bus.ICACHE_ADDRESS !== 32'h0)
      $display("FAIL wrap got pc=%h pc4=%h addr=%h want fffffffc/00000000/00000000", IF_ID_PC,
               IF_ID_PC_PLUS4, bus.ICACHE_ADDRESS);
    else passes++;
    run_seq("wrap_b", 3);
  endtask

  task automatic test_random();
    logic        st, br;
    logic [31:0] tg;
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      lat_cfg = $urandom_range(1, 6);
      st = ($urandom_range(0, 9) < 3);
      br = ($urandom_range(0, 99) < 8);
      tg = $urandom;
      cycle(st, br, tg);
      checks++;
      if (dut_snap() !== model_snap())
        $display("FAIL random cyc%0d dut=%h model=%h", i, dut_snap(), model_snap());
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_hit_stream();
    test_miss();
    test_redirect_miss();
    test_stall_skid();
    test_hold_branch();
    test_reset_mid_and_wrap();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
